// File: rtl/write_to_register.sv
// Serial write engine for one AD9951 DDS channel: shifts a left-aligned byte string out MSB-first on SDIO under chip select.
// Optional build macro WRITE_TO_REGISTER_CS_GUARD_EN adds a GUARD state that keeps chip select high for 2 extra periods.
module write_to_register #(
    parameter int LENGTH_BIT_COUNT = 3,
    parameter int MAXLENGTH        = 7,
    parameter int MAXLENGTH8       = MAXLENGTH * 8
) (
    input  logic                        SPI_clk,
    input  logic                        reset,
    input  logic [LENGTH_BIT_COUNT-1:0] registerData_Bytes,
    input  logic [MAXLENGTH8-1:0]       registerData,
    input  logic                        registerDataReady,
    output logic                        busy,
    output logic                        wr_rcsbar,
    output logic                        rsdio
);

    localparam int CW = LENGTH_BIT_COUNT + 3;

`ifdef WRITE_TO_REGISTER_CS_GUARD_EN
    typedef enum logic [1:0] {IDLE, SHIFT, ST_END, GUARD} state_t;
    logic guard_cnt;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, ST_END} state_t;
`endif

    state_t                      state;
    logic                        ready_q;
    logic [MAXLENGTH8-1:0]       shreg;
    logic [CW-1:0]               cnt;
    logic [LENGTH_BIT_COUNT-1:0] bytes_c;
    logic [CW-1:0]               start_cnt;
    logic                        start;

    function automatic logic [LENGTH_BIT_COUNT-1:0] clamp_bytes(input logic [LENGTH_BIT_COUNT-1:0] b);
        int v;
        v = int'(b);
        if (v > MAXLENGTH) v = MAXLENGTH;
        return LENGTH_BIT_COUNT'(v);
    endfunction

    always_comb begin
        bytes_c   = clamp_bytes(registerData_Bytes);
        start_cnt = {bytes_c, 3'b000} - CW'(1);
        // ready_q resets high so a request already high across reset is not a rising edge
        start     = registerDataReady && !ready_q && (state == IDLE);
    end

    // All state advances on the falling edge so SDIO is centred on the DDS rising-edge sample
    always_ff @(negedge SPI_clk) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            wr_rcsbar <= 1'b1;
            rsdio     <= 1'b0;
            ready_q   <= 1'b1;
`ifdef WRITE_TO_REGISTER_CS_GUARD_EN
            guard_cnt <= 1'b0;
`endif
        end else begin
            ready_q <= registerDataReady;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (bytes_c == '0) begin
                            // Empty transfer: no chip-select activity, busy still pulses once
                            state <= ST_END;
                        end else begin
                            shreg     <= registerData;
                            rsdio     <= registerData[MAXLENGTH8-1];
                            wr_rcsbar <= 1'b0;
                            cnt       <= start_cnt;
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        shreg <= shreg << 1;
                        rsdio <= shreg[MAXLENGTH8-2];
                        cnt   <= cnt - CW'(1);
                    end else begin
                        wr_rcsbar <= 1'b1;
                        rsdio     <= 1'b0;
                        state     <= ST_END;
                    end
                end
                ST_END: begin
`ifdef WRITE_TO_REGISTER_CS_GUARD_EN
                    guard_cnt <= 1'b1;
                    state     <= GUARD;
`else
                    busy  <= 1'b0;
                    state <= IDLE;
`endif
                end
`ifdef WRITE_TO_REGISTER_CS_GUARD_EN
                GUARD: begin
                    if (guard_cnt == 1'b0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        guard_cnt <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_to_register.sv
// Self-checking bench for write_to_register: per-cycle scoreboard of {busy, wr_rcsbar, rsdio} plus a vector table.
module tb_write_to_register;

`ifdef WRITE_TO_REGISTER_CS_GUARD_EN
    localparam int G = 2;
`else
    localparam int G = 0;
`endif

    logic        SPI_clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  registerData_Bytes = 3'd0;
    logic [55:0] registerData = '0;
    logic        registerDataReady = 1'b1;
    logic        busy, wr_rcsbar, rsdio;

    write_to_register dut (
        .SPI_clk(SPI_clk),
        .reset(reset),
        .registerData_Bytes(registerData_Bytes),
        .registerData(registerData),
        .registerDataReady(registerDataReady),
        .busy(busy),
        .wr_rcsbar(wr_rcsbar),
        .rsdio(rsdio)
    );

    always #5 SPI_clk = ~SPI_clk;

    typedef struct { logic b; logic cs; logic sd; } exp_t;
    typedef struct { logic [2:0] bytes; logic [55:0] data; int exp_cs_low; int exp_busy_hi; } vec_t;

    exp_t q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   cyc = 0;
    int   cs_lows = 0;
    int   busy_hi = 0;

    task automatic push_idle(input int n);
        exp_t e;
        e.b = 1'b0; e.cs = 1'b1; e.sd = 1'b0;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    // Expected outputs for the cycles following a start; includes one trailing idle cycle.
    task automatic push_frame(input logic [2:0] bytes, input logic [55:0] data);
        exp_t e;
        int n, tot;
        n   = 8 * int'(bytes);
        tot = n + 1 + G;
        for (int i = 1; i <= tot + 1; i++) begin
            e.b  = (i <= tot);
            e.cs = !(i <= n);
            e.sd = (i <= n) ? data[56 - i] : 1'b0;
            q.push_back(e);
        end
    endtask

    task automatic step();
        exp_t e;
        @(posedge SPI_clk);
        #1;
        cyc++;
        cs_lows += (wr_rcsbar == 1'b0) ? 1 : 0;
        busy_hi += (busy == 1'b1) ? 1 : 0;
        if (q.size() > 0) begin
            e = q.pop_front();
            total_cnt++;
            if (busy === e.b && wr_rcsbar === e.cs && rsdio === e.sd)
                pass_cnt++;
            else
                $display("FAIL cycle %0d outputs: busy/cs/sdio got %b%b%b want %b%b%b",
                         cyc, busy, wr_rcsbar, rsdio, e.b, e.cs, e.sd);
        end
    endtask

    task automatic drain();
        while (q.size() > 0) step();
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total_cnt++;
        if (got == want) pass_cnt++;
        else $display("FAIL %s: got %0d want %0d", name, got, want);
    endtask

    task automatic run_vec(input vec_t v);
        registerData_Bytes = v.bytes;
        registerData       = v.data;
        registerDataReady  = 1'b1;
        cs_lows = 0;
        busy_hi = 0;
        push_frame(v.bytes, v.data);
        step();
        registerDataReady  = 1'b0;
        registerData       = ~v.data;
        registerData_Bytes = 3'd0;
        drain();
        check_int("cs_low_periods", cs_lows, v.exp_cs_low);
        check_int("busy_high_periods", busy_hi, v.exp_busy_hi);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{3'd2, 56'h12340000000000, 16, 17 + G};
        vecs[1] = '{3'd7, 56'hFF00AA550FF081, 56, 57 + G};
        vecs[2] = '{3'd0, 56'hFFFFFFFFFFFFFF, 0,  1 + G};
        vecs[3] = '{3'd1, 56'hA5000000000000, 8,  9 + G};
        vecs[4] = '{3'd4, 56'h8001C37E000000, 32, 33 + G};

        // Reset state with the request already high, then release: no start
        repeat (2) @(posedge SPI_clk);
        #1;
        push_idle(3);
        drain();
        reset = 1'b0;
        push_idle(4);
        drain();
        registerDataReady = 1'b0;
        push_idle(1);
        drain();

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Request held high through and after the transfer: only one frame
        registerData_Bytes = 3'd1;
        registerData       = 56'hC3000000000000;
        registerDataReady  = 1'b1;
        push_frame(3'd1, 56'hC3000000000000);
        drain();
        push_idle(5);
        drain();
        registerDataReady = 1'b0;
        push_idle(1);
        drain();
        run_vec('{3'd1, 56'h3C000000000000, 8, 9 + G});

        // Reset at bit 5 of a 4-byte frame, request kept high afterwards
        registerData_Bytes = 3'd4;
        registerData       = 56'hDEADBEEF000000;
        registerDataReady  = 1'b1;
        push_frame(3'd4, 56'hDEADBEEF000000);
        repeat (5) step();
        q.delete();
        reset = 1'b1;
        push_idle(1);
        drain();
        reset = 1'b0;
        push_idle(4);
        drain();
        registerDataReady = 1'b0;
        push_idle(1);
        drain();

        // A fresh request after the aborted frame works normally
        run_vec('{3'd2, 56'h5AF00000000000, 16, 17 + G});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
